grid_mem_arbiter: RTL and testbench
===================================

# grid_mem_arbiter

Arbitrates the single-port tetris grid RAM between three requesters: display scan-out (port 0, read-only), the game FSM (port 1) and the line-clear engine (port 2). It issues registered one-hot grants and supports locked multi-cycle bursts for read-modify-write sequences, with a bounded hold time. It returns read data with a per-port valid strobe, and sits between the requesters and the grid RAM.

## Interface
- `ADDR_W`, default 8: grid address width (cells 0-251).
- `DATA_W`, default 8: grid cell width.
- `MAX_HOLD`, default 16: maximum consecutive granted cycles per lock; legal range 2-255.
- `clk` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 3: per-port access request.
- `lock` in 3: per-port request to keep the grant after the current cycle.
- `addr0`, `addr1`, `addr2` in ADDR_W each: per-port address.
- `wdata1`, `wdata2` in DATA_W each: write data for ports 1 and 2.
- `we1`, `we2` in 1 each: write enable for ports 1 and 2. Port 0 never writes.
- `gnt` out 3: registered one-hot grant, or all zero.
- `rvalid` out 3: one-cycle read-data strobe per port.
- `rdata` out DATA_W: registered copy of `mem_rdata`, shared by all ports.
- `hold_timeout` out 1: one-cycle pulse when a lock is force-released.
- `mem_addr` out ADDR_W, `mem_wdata` out DATA_W, `mem_we` out 1: RAM command.
- `mem_rdata` in DATA_W: RAM read data, valid one cycle after the address.

## Operation
- States:
  - S_IDLE: `gnt` = 0.
  - S_OWN: `gnt[k]` = 1, where k is the owner index.
  - The state, owner index and `hold_cnt` are all registered.
- Arbitration point: every rising edge, except while S_OWN is retaining a lock.
- At an arbitration point, `gnt` selects the winning `req` bit. With no `req` set, the next state is S_IDLE.
- Priority: port 0 beats ports 1 and 2. The choice between ports 1 and 2 is set by the Configuration section.
- Retain rule: in S_OWN, if `req[k]` and `lock[k]` are both set and `hold_cnt` < MAX_HOLD-1, then:
  - the grant stays on port k;
  - `hold_cnt` increments;
  - no other port is considered.
- Forced release: if `req[k]` and `lock[k]` are set and `hold_cnt` == MAX_HOLD-1, then:
  - port k is excluded from that arbitration;
  - `hold_timeout` pulses;
  - if no other port requests, the next state is S_IDLE for one cycle.
- `hold_cnt` loads 0 on every new grant and on entry to S_IDLE.
- An access occurs in a cycle only when `gnt[k]` and `req[k]` are both set.
- Combinational command mux during an access:
  - `mem_addr` = `addrk`;
  - `mem_wdata` = `wdatak`;
  - `mem_we` = `wek` (always 0 for port 0).
- With no access:
  - `mem_we` = 0;
  - `mem_addr` = 0;
  - `mem_wdata` = 0.
- Read access (`mem_we` = 0):
  - the next cycle, `rdata` = `mem_rdata`;
  - `rvalid[k]` = 1 for the port that issued the read, tracked by a registered index, independent of the current `gnt`.
- Write access: no `rvalid` pulse.
- Width rules:
  - ports are addressed by 2-bit indices 0-2;
  - `hold_cnt` is 8 bits and saturates at the limit, never wrapping.

## Timing
- Reset values:
  - `gnt` = 0;
  - `rvalid` = 0;
  - `rdata` = 0;
  - `hold_timeout` = 0;
  - `mem_we` = 0;
  - `mem_addr` = 0;
  - `mem_wdata` = 0;
  - state = S_IDLE;
  - `hold_cnt` = 0;
  - round-robin pointer = 1.
- Reset mid-burst: the grant drops and any read in flight gets no `rvalid`.
- Grant latency: `req` asserted in cycle N gives `gnt` in cycle N+1 at the earliest.
- Read latency: an access in cycle N+1 gives `rvalid` and `rdata` in cycle N+2.
- Single-access ownership: `lock` = 0 means one access per grant. A continuing `req` re-arbitrates every cycle and may win back to back.
- If `req[k]` drops while granted, no access occurs. The grant still ends at the next arbitration point.
- Port 0 worst-case wait: MAX_HOLD+1 cycles from `req` to `gnt`.
- `rvalid` for the previous owner and a new grant for another port may occur in the same cycle.

## Configuration
- `GRID_ARB_RR_EN` defined: ports 1 and 2 are round-robin.
  - A pointer names the preferred port and updates to the other port whenever port 1 or port 2 wins.
  - Port 0 wins do not move the pointer.
- `GRID_ARB_RR_EN` undefined: fixed priority, port 1 over port 2. No pointer register is built.

## Test plan
- Reset, then `req` = 3'b010, `addr1` = 8'd17, `we1` = 0, RAM[17] = 8'h03:
  - `gnt` = 3'b010 one cycle after `req`;
  - `rvalid[1]` and `rdata` = 8'h03 one cycle after that.
- `req` = 3'b111 in the same cycle:
  - `gnt` = 3'b001 first;
  - then 3'b010, then 3'b100 with `GRID_ARB_RR_EN` defined;
  - 3'b010 repeatedly without it.
- Port 2 holds `req` and `lock` high while port 1 requests, with MAX_HOLD = 4:
  - `gnt[2]` for 4 cycles;
  - `hold_timeout` pulses;
  - `gnt` = 3'b010 on the next cycle.
- Port 1 writes `addr1` = 8'd229, `wdata1` = 8'h05 under lock, then reads the same address:
  - `mem_we` = 1 for exactly one cycle;
  - the read returns 8'h05 with `rvalid[1]`;
  - no `rvalid` pulse on the write.
- Assert `reset` the cycle after a port 0 read access:
  - `rvalid` stays 0;
  - `gnt` = 0;
  - state returns to S_IDLE.
- Port 1 drops `req` while granted:
  - `mem_we` = 0 and no `rvalid`;
  - the arbiter returns to S_IDLE, or grants the next requester.

Source files
------------

// File: rtl/grid_mem_arbiter_if.sv
// Requester and grid-RAM bus bundle for grid_mem_arbiter.
// The master side is the requester/RAM environment. The slave side is the arbiter.
interface grid_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic [2:0]        req;
  logic [2:0]        lock;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [DATA_W-1:0] wdata1;
  logic [DATA_W-1:0] wdata2;
  logic              we1;
  logic              we2;
  logic [2:0]        gnt;
  logic [2:0]        rvalid;
  logic [DATA_W-1:0] rdata;
  logic              hold_timeout;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req, lock, addr0, addr1, addr2, wdata1, wdata2, we1, we2, mem_rdata,
    input  gnt, rvalid, rdata, hold_timeout, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  req, lock, addr0, addr1, addr2, wdata1, wdata2, we1, we2, mem_rdata,
    output gnt, rvalid, rdata, hold_timeout, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/grid_mem_arbiter.sv
// Single-port grid RAM arbiter: display (0), game FSM (1), line-clear (2), with bounded lock bursts.
// Optional macro GRID_ARB_RR_EN: round-robin between ports 1 and 2 (default: port 1 beats port 2).
module grid_mem_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              reset,
  grid_mem_arbiter_if.slave bus
);

  localparam int unsigned HOLD_W = 8;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t            r_state;
  logic [1:0]        r_owner;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [2:0]        r_gnt;
  logic [2:0]        r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_hold_timeout;
`ifdef GRID_ARB_RR_EN
  logic [1:0]        r_rr_ptr;
`endif

  logic [2:0]        w_owner_oh;
  logic              w_owner_locked;
  logic              w_retain;
  logic              w_force;
  logic [2:0]        w_cand;
  logic              w_any;
  logic [1:0]        w_win;
  logic              w_access;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_mem_we;

  assign w_owner_oh     = 3'b001 << r_owner;
  assign w_owner_locked = (r_state == S_OWN) && (|(w_owner_oh & bus.req & bus.lock));
  assign w_retain       = w_owner_locked && (r_hold_cnt < HOLD_LAST);
  assign w_force        = w_owner_locked && (r_hold_cnt >= HOLD_LAST);
  // A force-released owner sits out the arbitration that ends its lock.
  assign w_cand         = bus.req & ~(w_force ? w_owner_oh : 3'b000);
  assign w_any          = |w_cand;
  assign w_access       = |(r_gnt & bus.req);

  always_comb begin
    w_win = 2'd0;
    if (w_cand[0]) begin
      w_win = 2'd0;
    end else if (w_cand[1] && w_cand[2]) begin
`ifdef GRID_ARB_RR_EN
      w_win = r_rr_ptr;
`else
      w_win = 2'd1;
`endif
    end else if (w_cand[1]) begin
      w_win = 2'd1;
    end else if (w_cand[2]) begin
      w_win = 2'd2;
    end
  end

  // RAM command follows the owner only while it is actually requesting.
  always_comb begin
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_mem_we    = 1'b0;
    if (w_access) begin
      case (r_owner)
        2'd0: w_mem_addr = bus.addr0;
        2'd1: begin
          w_mem_addr  = bus.addr1;
          w_mem_wdata = bus.wdata1;
          w_mem_we    = bus.we1;
        end
        2'd2: begin
          w_mem_addr  = bus.addr2;
          w_mem_wdata = bus.wdata2;
          w_mem_we    = bus.we2;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_owner        <= 2'd0;
      r_hold_cnt     <= '0;
      r_gnt          <= 3'b000;
      r_rvalid       <= 3'b000;
      r_rdata        <= '0;
      r_hold_timeout <= 1'b0;
`ifdef GRID_ARB_RR_EN
      r_rr_ptr       <= 2'd1;
`endif
    end else begin
      r_hold_timeout <= w_force;
      r_rdata        <= bus.mem_rdata;
      r_rvalid       <= (w_access && !w_mem_we) ? w_owner_oh : 3'b000;
      if (w_retain) begin
        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      end else if (w_any) begin
        r_state    <= S_OWN;
        r_owner    <= w_win;
        r_gnt      <= 3'b001 << w_win;
        r_hold_cnt <= '0;
`ifdef GRID_ARB_RR_EN
        if (w_win == 2'd1) begin
          r_rr_ptr <= 2'd2;
        end else if (w_win == 2'd2) begin
          r_rr_ptr <= 2'd1;
        end
`endif
      end else begin
        r_state    <= S_IDLE;
        r_gnt      <= 3'b000;
        r_hold_cnt <= '0;
      end
    end
  end

  assign bus.gnt          = r_gnt;
  assign bus.rvalid       = r_rvalid;
  assign bus.rdata        = r_rdata;
  assign bus.hold_timeout = r_hold_timeout;
  assign bus.mem_addr     = w_mem_addr;
  assign bus.mem_wdata    = w_mem_wdata;
  assign bus.mem_we       = w_mem_we;

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Directed bench for grid_mem_arbiter (MAX_HOLD = 4) with a combinational-read grid RAM model.
module tb_grid_mem_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  grid_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  grid_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // RAM model: cell i resets to i ^ 8'h12, so RAM[17] = 8'h03.
  logic [7:0] ram [0:255];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h12;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = ram[bus.mem_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req = 3'b000; bus.lock = 3'b000;
    bus.addr0 = 8'd0; bus.addr1 = 8'd0; bus.addr2 = 8'd0;
    bus.wdata1 = 8'd0; bus.wdata2 = 8'd0; bus.we1 = 1'b0; bus.we2 = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (bus.gnt !== 3'b000 || bus.rvalid !== 3'b000 || bus.hold_timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: gnt=%b rvalid=%b hto=%b want 000 000 0", bus.gnt, bus.rvalid, bus.hold_timeout);
    end
    n_checks++;
    if (bus.rdata !== 8'h00 || bus.mem_we !== 1'b0 || bus.mem_addr !== 8'h00 || bus.mem_wdata !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_mem: rdata=%h we=%b addr=%h wdata=%h want 00 0 00 00", bus.rdata, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (bus.gnt !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_idle: gnt=%b want 000", bus.gnt);
    end
  endtask

  task automatic test_priority();
    logic [2:0] exp2;
`ifdef GRID_ARB_RR_EN
    exp2 = 3'b100;
`else
    exp2 = 3'b010;
`endif
    bus.req = 3'b111; bus.addr0 = 8'd1; bus.addr1 = 8'd2; bus.addr2 = 8'd3;
    tick();
    n_checks++;
    if (bus.gnt !== 3'b001) begin
      n_errors++;
      $display("FAIL prio_port0: gnt=%b want 001", bus.gnt);
    end
    bus.req = 3'b110;
    tick();
    n_checks++;
    if (bus.gnt !== 3'b010 || bus.rvalid !== 3'b000) begin
      n_errors++;
      $display("FAIL prio_second: gnt=%b rvalid=%b want 010 000", bus.gnt, bus.rvalid);
    end
    tick();
    n_checks++;
    if (bus.gnt !== exp2) begin
      n_errors++;
      $display("FAIL prio_third: gnt=%b want %b", bus.gnt, exp2);
    end
    tick();
    n_checks++;
    if (bus.gnt !== 3'b010) begin
      n_errors++;
      $display("FAIL prio_fourth: gnt=%b want 010", bus.gnt);
    end
    idle_inputs();
    repeat (2) tick();
  endtask

  task automatic test_single_read();
    bus.req = 3'b010; bus.addr1 = 8'd17; bus.we1 = 1'b0;
    tick();
    n_checks++;
    if (bus.gnt !== 3'b010 || bus.mem_addr !== 8'd17 || bus.mem_we !== 1'b0) begin
      n_errors++;
      $display("FAIL read_grant: gnt=%b addr=%0d we=%b want 010 17 0", bus.gnt, bus.mem_addr, bus.mem_we);
    end
    tick();
    bus.req = 3'b000;
    n_checks++;
    if (bus.rvalid !== 3'b010 || bus.rdata !== 8'h03) begin
      n_errors++;
      $display("FAIL read_data: rvalid=%b rdata=%h want 010 03", bus.rvalid, bus.rdata);
    end
    tick();
    n_checks++;
    if (bus.gnt !== 3'b000 || bus.rvalid !== 3'b000) begin
      n_errors++;
      $display("FAIL read_end: gnt=%b rvalid=%b want 000 000", bus.gnt, bus.rvalid);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_hold_timeout();
    bus.req = 3'b100; bus.lock = 3'b100; bus.addr2 = 8'd5; bus.we2 = 1'b0;
    tick();
    bus.req = 3'b110; bus.addr1 = 8'd9;
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if (bus.gnt !== 3'b100 || bus.hold_timeout !== 1'b0) begin
        n_errors++;
        $display("FAIL hold_cycle%0d: gnt=%b hto=%b want 100 0", c, bus.gnt, bus.hold_timeout);
      end
      tick();
    end
    n_checks++;
    if (bus.gnt !== 3'b010 || bus.hold_timeout !== 1'b1) begin
      n_errors++;
      $display("FAIL hold_release: gnt=%b hto=%b want 010 1", bus.gnt, bus.hold_timeout);
    end
    n_checks++;
    if (bus.rvalid !== 3'b100 || bus.rdata !== 8'h17) begin
      n_errors++;
      $display("FAIL hold_rvalid_overlap: rvalid=%b rdata=%h want 100 17", bus.rvalid, bus.rdata);
    end
    idle_inputs();
    tick();
    n_checks++;
    if (bus.hold_timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL hold_pulse_width: hto=%b want 0", bus.hold_timeout);
    end
    repeat (2) tick();
  endtask

  task automatic test_write_read();
    bus.req = 3'b010; bus.lock = 3'b010; bus.addr1 = 8'd229; bus.wdata1 = 8'h05; bus.we1 = 1'b1;
    tick();
    n_checks++;
    if (bus.gnt !== 3'b010 || bus.mem_we !== 1'b1 || bus.mem_addr !== 8'd229 || bus.mem_wdata !== 8'h05) begin
      n_errors++;
      $display("FAIL wr_cmd: gnt=%b we=%b addr=%0d wdata=%h want 010 1 229 05", bus.gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    bus.we1 = 1'b0; bus.lock = 3'b000;
    #1;
    n_checks++;
    if (bus.gnt !== 3'b010 || bus.rvalid !== 3'b000 || bus.mem_we !== 1'b0) begin
      n_errors++;
      $display("FAIL wr_no_rvalid: gnt=%b rvalid=%b we=%b want 010 000 0", bus.gnt, bus.rvalid, bus.mem_we);
    end
    tick();
    bus.req = 3'b000;
    #1;
    n_checks++;
    if (bus.rvalid !== 3'b010 || bus.rdata !== 8'h05 || bus.mem_we !== 1'b0) begin
      n_errors++;
      $display("FAIL wr_readback: rvalid=%b rdata=%h we=%b want 010 05 0", bus.rvalid, bus.rdata, bus.mem_we);
    end
    tick();
    n_checks++;
    if (bus.gnt !== 3'b000 || bus.rvalid !== 3'b000) begin
      n_errors++;
      $display("FAIL wr_end: gnt=%b rvalid=%b want 000 000", bus.gnt, bus.rvalid);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    bus.req = 3'b001; bus.addr0 = 8'd17;
    tick();
    n_checks++;
    if (bus.gnt !== 3'b001 || bus.mem_addr !== 8'd17) begin
      n_errors++;
      $display("FAIL rst_mid_grant: gnt=%b addr=%0d want 001 17", bus.gnt, bus.mem_addr);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if (bus.rvalid !== 3'b000 || bus.gnt !== 3'b000) begin
      n_errors++;
      $display("FAIL rst_mid_drop: rvalid=%b gnt=%b want 000 000", bus.rvalid, bus.gnt);
    end
    reset = 1'b0;
    idle_inputs();
    tick();
    n_checks++;
    if (bus.rvalid !== 3'b000 || bus.gnt !== 3'b000 || bus.mem_we !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_mid_idle: rvalid=%b gnt=%b we=%b want 000 000 0", bus.rvalid, bus.gnt, bus.mem_we);
    end
  endtask

  task automatic test_req_drop();
    bus.req = 3'b010; bus.addr1 = 8'd40; bus.wdata1 = 8'h99; bus.we1 = 1'b1;
    tick();
    bus.req = 3'b000;
    #1;
    n_checks++;
    if (bus.gnt !== 3'b010 || bus.mem_we !== 1'b0 || bus.mem_addr !== 8'd0) begin
      n_errors++;
      $display("FAIL drop_no_access: gnt=%b we=%b addr=%0d want 010 0 0", bus.gnt, bus.mem_we, bus.mem_addr);
    end
    tick();
    n_checks++;
    if (bus.gnt !== 3'b000 || bus.rvalid !== 3'b000 || ram[40] !== 8'h3a) begin
      n_errors++;
      $display("FAIL drop_idle: gnt=%b rvalid=%b ram40=%h want 000 000 3a", bus.gnt, bus.rvalid, ram[40]);
    end
    bus.req = 3'b010; bus.we1 = 1'b0;
    tick();
    bus.req = 3'b100; bus.addr2 = 8'd7;
    tick();
    n_checks++;
    if (bus.gnt !== 3'b100 || bus.rvalid !== 3'b000) begin
      n_errors++;
      $display("FAIL drop_next_grant: gnt=%b rvalid=%b want 100 000", bus.gnt, bus.rvalid);
    end
    idle_inputs();
    repeat (2) tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_priority();
    test_single_read();
    test_hold_timeout();
    test_write_read();
    test_reset_mid_burst();
    test_req_drop();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
